// File: rtl/top_downsample.sv
// rtl/top_downsample.sv - sequential 2x2 average pooling, one output word per clock
// Optional macro DOWNSAMPLE_ROUND_EN: add 2 before the arithmetic shift (round half up).
module top_downsample #(
    parameter int number_of_row = 8,
    parameter int length        = 16,
    parameter int frac          = 8
) (
    input  logic                                                   clk,
    input  logic                                                   rst,
    input  logic                                                   start,
    input  logic [length*number_of_row*number_of_row-1:0]          din,
    output logic [length*(number_of_row/2)*(number_of_row/2)-1:0]  dout,
    output logic                                                   busy,
    output logic                                                   done
);

    localparam int N  = number_of_row;
    localparam int M  = number_of_row / 2;
    localparam int NE = M * M;
    localparam int IW = (NE > 1) ? $clog2(NE) : 1;
    localparam int WI = $clog2(N * N);

    if (number_of_row < 2 || (number_of_row % 2) != 0 || frac > length) begin : g_param_check
        $error("top_downsample: invalid parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                   state, state_nx;
    logic [IW-1:0]            idx;
    logic                     last;
    logic [length*N*N-1:0]    din_q;
    logic [length-1:0]        in_w [N*N];
    logic [WI-1:0]            w00, w01, w10, w11;
    logic [length+1:0]        sum, sum_adj;
    logic [length-1:0]        avg;

    for (genvar i = 0; i < N * N; i++) begin : g_unpack
        assign in_w[i] = din_q[i*length +: length];
    end

    assign last = (idx == IW'(NE - 1));

    // Top-left word of the 2x2 block feeding output element idx, then its neighbours.
    always_comb begin
        w00 = WI'((int'(idx) / M) * 2 * N + (int'(idx) % M) * 2);
        w01 = WI'((int'(idx) / M) * 2 * N + (int'(idx) % M) * 2 + 1);
        w10 = WI'((int'(idx) / M) * 2 * N + (int'(idx) % M) * 2 + N);
        w11 = WI'((int'(idx) / M) * 2 * N + (int'(idx) % M) * 2 + N + 1);
    end

    always_comb begin
        sum = {{2{in_w[w00][length-1]}}, in_w[w00]}
            + {{2{in_w[w01][length-1]}}, in_w[w01]}
            + {{2{in_w[w10][length-1]}}, in_w[w10]}
            + {{2{in_w[w11][length-1]}}, in_w[w11]};
`ifdef DOWNSAMPLE_ROUND_EN
        sum_adj = sum + (length+2)'(2);
`else
        sum_adj = sum;
`endif
        avg = length'($signed(sum_adj) >>> 2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (start) state_nx = S_RUN;
            S_RUN:   if (last)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state == S_RUN);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q <= '0;
            idx   <= '0;
            dout  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        din_q <= din;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    for (int k = 0; k < NE; k++) begin
                        if (idx == IW'(k)) dout[k*length +: length] <= avg;
                    end
                    idx <= last ? '0 : idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_top_downsample.sv
// tb/tb_top_downsample.sv - randomized and directed bench for top_downsample against an arithmetic model
module tb_top_downsample;

    localparam int N  = 8;
    localparam int M  = 4;
    localparam int L  = 16;
    localparam int NN = N * N;
    localparam int MM = M * M;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [NN-1:0][L-1:0]  din;
    logic [MM-1:0][L-1:0]  dout;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    top_downsample #(.number_of_row(N), .length(L), .frac(8)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .din   (din),
        .dout  (dout),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [L*MM-1:0] obs, input logic [L*MM-1:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: average of each 2x2 block, floor (or round-half-up) division by 4.
    function automatic void model(input logic [NN-1:0][L-1:0] d, output logic [MM-1:0][L-1:0] e);
        int s;
        for (int r = 0; r < M; r++) begin
            for (int c = 0; c < M; c++) begin
                s = int'($signed(d[(2*r)*N + 2*c]))   + int'($signed(d[(2*r)*N + 2*c + 1]))
                  + int'($signed(d[(2*r+1)*N + 2*c])) + int'($signed(d[(2*r+1)*N + 2*c + 1]));
`ifdef DOWNSAMPLE_ROUND_EN
                s = s + 2;
`endif
                e[r*M + c] = L'(s >>> 2);
            end
        end
    endfunction

    task automatic rand_din();
        for (int i = 0; i < NN; i++) din[i] = L'($urandom);
    endtask

    // One full run; optional re-pulse of start with fresh din at cycle restart_at.
    task automatic run(input string tag, input int restart_at);
        logic [MM-1:0][L-1:0] exp;
        int lat;
        int ndone;
        model(din, exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        lat   = 0;
        ndone = 0;
        for (int k = 1; k <= MM + 4; k++) begin
            if (k == restart_at) begin
                rand_din();
                start = 1'b1;
            end
            tick();
            if (k == restart_at) start = 1'b0;
            if (k == MM - 1) chk({tag, " busy_before_done"}, {busy, done}, 2'b10);
            if (k == MM)     chk({tag, " busy_in_done"},     {busy, done}, 2'b01);
            if (done) begin
                ndone++;
                if (lat == 0) lat = k;
            end
        end
        chk({tag, " latency"}, lat, MM);
        chk({tag, " done_count"}, ndone, 1);
        chk({tag, " dout"}, dout, exp);
    endtask

    initial begin
        logic [MM-1:0][L-1:0] exp;
        int ndone;
        int gap;

        rst   = 1'b0;
        start = 1'b0;
        din   = '0;
        tick();
        tick();
        chk("reset_dout", dout, '0);
        chk("reset_flags", {busy, done}, 2'b00);
        rst = 1'b1;
        tick();

        for (int i = 0; i < NN; i++) din[i] = L'(35 + 10 * i);
        run("ramp", 0);
        chk("ramp_out00", dout[0], 80);
        chk("ramp_out33", dout[MM-1], 620);

        for (int t = 0; t < 3; t++) begin
            rand_din();
            run("random", 0);
        end

        rand_din();
        din[0] = 16'd1; din[1] = 16'd1; din[N] = 16'd0; din[N+1] = 16'd0;
        run("round_pos", 0);
`ifdef DOWNSAMPLE_ROUND_EN
        chk("round_pos_out00", dout[0], 16'd1);
`else
        chk("round_pos_out00", dout[0], 16'd0);
`endif

        rand_din();
        din[0] = 16'hFFFF; din[1] = 16'hFFFF; din[N] = 16'hFFFF; din[N+1] = 16'hFFFE;
        run("round_neg", 0);
`ifdef DOWNSAMPLE_ROUND_EN
        chk("round_neg_out00", dout[0], 16'hFFFF);
`else
        chk("round_neg_out00", dout[0], 16'hFFFE);
`endif

        for (int i = 0; i < NN; i++) din[i] = 16'h7FFF;
        run("max", 0);
        chk("max_all", dout, {MM{16'h7FFF}});
        for (int i = 0; i < NN; i++) din[i] = 16'h8000;
        run("min", 0);
        chk("min_all", dout, {MM{16'h8000}});

        rand_din();
        run("busy_restart", 5);

        rand_din();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 1; k < 7; k++) tick();
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_dout", dout, '0);
        chk("midreset_flags", {busy, done}, 2'b00);
        tick();
        rst = 1'b1;
        ndone = 0;
        for (int k = 0; k < MM + 4; k++) begin
            tick();
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);
        rand_din();
        run("after_reset", 0);

        rand_din();
        model(din, exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        gap = 0;
        while (!done && gap < MM + 4) begin
            tick();
            gap++;
        end
        chk("b2b_first_done", {gap[7:0], done}, {8'(MM), 1'b1});
        chk("b2b_first_dout", dout, exp);
        rand_din();
        model(din, exp);
        start = 1'b1;
        tick();
        chk("b2b_start_in_done_ignored", {busy, done}, 2'b00);
        tick();
        start = 1'b0;
        gap = 2;
        while (!done && gap < 2 * MM + 8) begin
            tick();
            gap++;
        end
        chk("b2b_gap", gap, MM + 2);
        chk("b2b_second_dout", dout, exp);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
